gpio_tx_driver: RTL and testbench
=================================

// Module: gpio_tx_driver
// PURPOSE
//  Transmit side of the GPIO port. Accepts WIDTH-bit words from the core over a valid/ready
//  handshake and buffers them in a small FIFO. Drives each word onto Gpio, then emits one
//  Ext_clk strobe (setup/high/low phases) so an external sampler can capture it.
//  Sits between the core's GPIO write path and the pads; the GPIO monitor observes its outputs.
// PARAMETERS
//  WIDTH         32  Gpio data width
//  FIFO_DEPTH    4   word buffer depth; power of 2, >=2
//  SETUP_CYCLES  1   Clk cycles Gpio is stable with Ext_clk low before the rising edge; >=1
//  HIGH_CYCLES   5   Clk cycles Ext_clk is held high; >=1
//  LOW_CYCLES    5   Clk cycles Ext_clk is held low after the high phase; >=1
// PORTS
//  Clk         in   1                      system clock, rising edge
//  Rst_n       in   1                      asynchronous active-low reset
//  Data_in     in   WIDTH                  word to transmit
//  Valid_in    in   1                      Data_in valid
//  Ready_out   out  1                      FIFO can accept a word this cycle
//  Gpio        out  WIDTH                  registered pad output
//  Ext_clk     out  1                      registered capture strobe
//  Busy        out  1                      FIFO non-empty or FSM not IDLE
//  Fifo_level  out  $clog2(FIFO_DEPTH)+1   words currently buffered
// BEHAVIOUR
//  Reset (async, Rst_n=0):
//   - Gpio=0, Ext_clk=0, Busy=0, Fifo_level=0; Ready_out=1; FSM=IDLE.
//   - FIFO pointers and phase counter cleared; Valid_in ignored.
//   - Mid-strobe reset drops Ext_clk immediately; buffered words are discarded.
//  Handshake:
//   - Push when Valid_in && Ready_out at a rising Clk edge.
//   - Ready_out = !full, combinational from registered level; no bypass when full.
//   - Push and pop in the same cycle: level unchanged.
//  FSM states: IDLE, SETUP, HIGH, LOW.
//   - IDLE: when FIFO non-empty, pop; Gpio<=head; cnt<=SETUP_CYCLES-1; ->SETUP.
//   - SETUP: Ext_clk=0; at cnt==0, Ext_clk<=1, cnt<=HIGH_CYCLES-1, ->HIGH; else cnt--.
//   - HIGH: Ext_clk=1; at cnt==0, Ext_clk<=0, cnt<=LOW_CYCLES-1, ->LOW; else cnt--.
//   - LOW: Ext_clk=0; at cnt==0:
//      - FIFO non-empty: pop, load Gpio, ->SETUP (back-to-back, no IDLE cycle);
//      - else ->IDLE.
//     Otherwise cnt--.
//  Timing:
//   - Word pushed at edge t into an empty FIFO with FSM IDLE: Gpio updates at edge t+1;
//     Ext_clk rises at edge t+1+SETUP_CYCLES.
//   - Ext_clk period per word = SETUP+HIGH+LOW cycles.
//   - Gpio changes only on the pop edge, never while Ext_clk=1.
//   - Gpio holds the last word indefinitely while IDLE; repeated equal words still strobe.
//  Sizing and status:
//   - Phase counter width = $clog2(max(SETUP,HIGH,LOW)+1); Fifo_level saturates at FIFO_DEPTH.
//   - Pointers wrap modulo FIFO_DEPTH; one extra bit distinguishes full from empty.
//   - Busy = (state!=IDLE) || (Fifo_level!=0).
// STRUCTURE
//  - gpio_tx_pkg: typedef enum logic [1:0] {IDLE,SETUP,HIGH,LOW} gpio_tx_state_e; default
//    phase-length constants.
//  - One sub-module gpio_tx_fifo (sync FIFO, async active-low reset, push/pop/full/empty/level).
//  - Top holds the FSM, phase counter and the Gpio/Ext_clk registers.
// TESTING
//  1 Reset: Rst_n=0 then release -> Gpio=0, Ext_clk=0, Ready_out=1, Busy=0, Fifo_level=0.
//  2 Single word 32'hDEADBEEF pushed at edge t (defaults) -> Gpio=DEADBEEF from t+1;
//    Ext_clk high on edges t+2..t+6, low t+7..t+11; Busy drops at t+12.
//  3 Back-to-back: push A5A5A5A5, 5A5A5A5A, 0, FFFFFFFF -> four strobes, period 11 cycles,
//    no IDLE gap; each Gpio value stable across its whole high phase.
//  4 Full: hold Valid_in with FSM stalled in HIGH, 5 pushes offered -> Ready_out=0 after 4,
//    Fifo_level=4, 5th word accepted only on the cycle after the next pop.
//  5 Reset mid-HIGH with 3 words queued -> Ext_clk=0 and Gpio=0 immediately, Fifo_level=0;
//    no further strobes after release.
//  6 Parameters SETUP=HIGH=LOW=1 -> period 3 cycles; simultaneous push/pop keeps level constant.

Source files
------------

// File: rtl/gpio_tx_pkg.sv
// gpio_tx_pkg: shared types and default timing for the GPIO transmit driver.
//   gpio_tx_state_e : strobe sequencer states (IDLE, SETUP, HIGH, LOW)
//   DEF_*           : default parameter values used by gpio_tx_driver
//   max3            : helper for sizing the phase counter
package gpio_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    HIGH  = 2'b10,
    LOW   = 2'b11
  } gpio_tx_state_e;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_HIGH_CYCLES  = 5;
  localparam int DEF_LOW_CYCLES   = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpio_tx_fifo.sv
// gpio_tx_fifo: synchronous word FIFO with async active-low reset.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request and word (ignored when full)
//   pop, rdata   : read request (ignored when empty) and head word (show-ahead)
//   full, empty  : status derived from the registered pointers
//   level        : words currently buffered, 0..DEPTH
module gpio_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_L = AW1'(DEPTH);
  localparam logic [AW:0] ONE_L   = AW1'(1);
  localparam logic [AW:0] ZERO_L  = AW1'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // The extra pointer bit makes the difference DEPTH when full and 0 when empty.
  assign level     = wr_ptr_r - rd_ptr_r;
  assign full      = (level == DEPTH_L);
  assign empty     = (level == ZERO_L);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; both may move in one cycle, leaving the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= ZERO_L;
      rd_ptr_r <= ZERO_L;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_L;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_L;
      end
    end
  end

  // Storage write; cleared on reset so discarded words never reappear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/gpio_tx_driver.sv
// gpio_tx_driver: buffers words from the core and presents each on Gpio followed
// by one Ext_clk strobe (setup, high, low phases) for an external sampler.
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   Data_in, Valid_in   : word offered by the core
//   Ready_out           : FIFO can take a word this cycle
//   Gpio, Ext_clk       : registered pad data and capture strobe
//   Busy                : words buffered or a strobe in progress
//   Fifo_level          : words currently buffered
module gpio_tx_driver
  import gpio_tx_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int HIGH_CYCLES  = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES   = DEF_LOW_CYCLES
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic [WIDTH-1:0]            Data_in,
  input  logic                        Valid_in,
  output logic                        Ready_out,
  output logic [WIDTH-1:0]            Gpio,
  output logic                        Ext_clk,
  output logic                        Busy,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_level
);

  localparam int CW = $clog2(max3(SETUP_CYCLES, HIGH_CYCLES, LOW_CYCLES) + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LD  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LD   = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  gpio_tx_state_e   state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] gpio_r, gpio_nxt_s;
  logic             ext_clk_r, ext_clk_nxt_s;
  logic             push_s, pop_s;
  logic             full_s, empty_s;
  logic [WIDTH-1:0] head_s;

  assign push_s    = Valid_in && !full_s;
  assign Ready_out = !full_s;
  assign Gpio      = gpio_r;
  assign Ext_clk   = ext_clk_r;
  assign Busy      = (state_r != IDLE) || !empty_s;

  gpio_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst_n),
    .push  (push_s),
    .wdata (Data_in),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (Fifo_level)
  );

  // Strobe sequencer: Gpio is only reloaded on a pop, which happens with Ext_clk low.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    gpio_nxt_s    = gpio_r;
    ext_clk_nxt_s = ext_clk_r;
    pop_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s         = 1'b1;
          gpio_nxt_s    = head_s;
          cnt_nxt_s     = SETUP_LD;
          ext_clk_nxt_s = 1'b0;
          state_nxt_s   = SETUP;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          ext_clk_nxt_s = 1'b1;
          cnt_nxt_s     = HIGH_LD;
          state_nxt_s   = HIGH;
        end else begin
          cnt_nxt_s     = cnt_r - CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt_r == CNT_ZERO) begin
          ext_clk_nxt_s = 1'b0;
          cnt_nxt_s     = LOW_LD;
          state_nxt_s   = LOW;
        end else begin
          cnt_nxt_s     = cnt_r - CNT_ONE;
        end
      end
      LOW: begin
        if (cnt_r == CNT_ZERO) begin
          if (!empty_s) begin
            // Back-to-back: next word goes straight to SETUP without an IDLE cycle.
            pop_s       = 1'b1;
            gpio_nxt_s  = head_s;
            cnt_nxt_s   = SETUP_LD;
            state_nxt_s = SETUP;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s     = cnt_r - CNT_ONE;
        end
      end
      default: begin
        ext_clk_nxt_s = 1'b0;
        cnt_nxt_s     = CNT_ZERO;
        state_nxt_s   = IDLE;
      end
    endcase
  end

  // Sequencer and pad registers; reset drops Ext_clk and Gpio immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      gpio_r    <= {WIDTH{1'b0}};
      ext_clk_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      gpio_r    <= gpio_nxt_s;
      ext_clk_r <= ext_clk_nxt_s;
    end
  end

endmodule

// File: tb/tb_gpio_tx_driver.sv
// tb_gpio_tx_driver: drives two driver instances (default timing and 1/1/1 timing)
// from one stimulus stream and compares every cycle against a word-timeline model:
// each accepted word starts at max(push+1, previous start + period) and the strobe
// phases follow from that start.
module tb_gpio_tx_driver;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic [31:0] Data_in = 32'h0;
  logic        Valid_in = 1'b0;

  logic        rdy0, ext0, busy0, rdy1, ext1, busy1;
  logic [31:0] gpio0, gpio1;
  logic [2:0]  lvl0, lvl1;

  gpio_tx_driver #(.WIDTH(32), .FIFO_DEPTH(4), .SETUP_CYCLES(1), .HIGH_CYCLES(5), .LOW_CYCLES(5)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Data_in(Data_in), .Valid_in(Valid_in), .Ready_out(rdy0),
    .Gpio(gpio0), .Ext_clk(ext0), .Busy(busy0), .Fifo_level(lvl0));

  gpio_tx_driver #(.WIDTH(32), .FIFO_DEPTH(4), .SETUP_CYCLES(1), .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Data_in(Data_in), .Valid_in(Valid_in), .Ready_out(rdy1),
    .Gpio(gpio1), .Ext_clk(ext1), .Busy(busy1), .Fifo_level(lvl1));

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Word timeline per instance: cycle it was accepted, cycle it was popped, data.
  int          m_push  [2][256];
  int          m_start [2][256];
  logic [31:0] m_data  [2][256];
  int          m_n     [2];

  function automatic int ph_s(input int k); return 1; endfunction
  function automatic int ph_h(input int k); return (k == 0) ? 5 : 1; endfunction
  function automatic int ph_l(input int k); return (k == 0) ? 5 : 1; endfunction

  function automatic int m_level(input int k, input int c);
    int n = 0;
    for (int i = 0; i < m_n[k]; i++)
      if (m_push[k][i] <= c && c < m_start[k][i]) n++;
    return n;
  endfunction

  function automatic logic m_ext(input int k, input int c);
    for (int i = 0; i < m_n[k]; i++)
      if (m_start[k][i] + ph_s(k) <= c && c < m_start[k][i] + ph_s(k) + ph_h(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_gpio(input int k, input int c);
    logic [31:0] g = 32'h0;
    for (int i = 0; i < m_n[k]; i++)
      if (m_start[k][i] <= c) g = m_data[k][i];
    return g;
  endfunction

  function automatic logic m_busy(input int k, input int c);
    for (int i = 0; i < m_n[k]; i++)
      if (m_push[k][i] <= c && c < m_start[k][i] + ph_s(k) + ph_h(k) + ph_l(k)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_push(input int k, input int e, input logic [31:0] d);
    int st;
    int p;
    if (m_n[k] < 256) begin
      p  = ph_s(k) + ph_h(k) + ph_l(k);
      st = e + 1;
      if (m_n[k] > 0 && m_start[k][m_n[k]-1] + p > st) st = m_start[k][m_n[k]-1] + p;
      m_push[k][m_n[k]]  = e;
      m_start[k][m_n[k]] = st;
      m_data[k][m_n[k]]  = d;
      m_n[k]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_dut(input int k, input logic [31:0] g, input logic e, input logic b,
                           input logic [2:0] l, input logic r);
    int lv;
    lv = m_level(k, cyc);
    chk($sformatf("d%0d_gpio", k), g, m_gpio(k, cyc));
    chk($sformatf("d%0d_ext_clk", k), {31'h0, e}, {31'h0, m_ext(k, cyc)});
    chk($sformatf("d%0d_busy", k), {31'h0, b}, {31'h0, m_busy(k, cyc)});
    chk($sformatf("d%0d_level", k), {29'h0, l}, 32'(lv));
    chk($sformatf("d%0d_ready", k), {31'h0, r}, (lv < 4) ? 32'h1 : 32'h0);
  endtask

  // One clock: record what the upcoming edge accepts, then compare both instances.
  task automatic tick();
    if (Rst_n && Valid_in)
      for (int k = 0; k < 2; k++)
        if (m_level(k, cyc) < 4) model_push(k, cyc + 1, Data_in);
    @(posedge Clk);
    cyc++;
    #1;
    check_dut(0, gpio0, ext0, busy0, lvl0, rdy0);
    check_dut(1, gpio1, ext1, busy1, lvl1, rdy1);
  endtask

  logic [31:0] words [4];
  int t;
  int rises;
  int last_rise;
  logic prev_ext;

  initial begin
    m_n[0] = 0;
    m_n[1] = 0;
    words[0] = 32'hA5A5A5A5;
    words[1] = 32'h5A5A5A5A;
    words[2] = 32'h00000000;
    words[3] = 32'hFFFFFFFF;

    // Reset state, during and after reset
    #2 Rst_n = 1'b0;
    repeat (3) tick();
    Rst_n = 1'b1;
    repeat (2) tick();

    // Single word: Gpio next edge, Ext_clk high 5 cycles, low 5, Busy drops after
    Valid_in = 1'b1;
    Data_in  = 32'hDEADBEEF;
    tick();
    t = cyc;
    Valid_in = 1'b0;
    Data_in  = 32'h0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 1) begin
        chk("single_gpio_t1", gpio0, 32'hDEADBEEF);
        chk("single_ext_t1", {31'h0, ext0}, 32'h0);
      end
      if (i == 2 || i == 6) chk("single_ext_high", {31'h0, ext0}, 32'h1);
      if (i == 7 || i == 11) chk("single_ext_low", {31'h0, ext0}, 32'h0);
      if (i == 11) chk("single_busy_t11", {31'h0, busy0}, 32'h1);
      if (i == 12) chk("single_busy_t12", {31'h0, busy0}, 32'h0);
    end
    repeat (5) tick();

    // Back-to-back: four strobes, 11-cycle period, no idle gap
    rises = 0;
    last_rise = 0;
    prev_ext = ext0;
    for (int i = 0; i < 60; i++) begin
      Valid_in = (i < 4);
      Data_in  = (i < 4) ? words[i] : 32'h0;
      tick();
      if (ext0 && !prev_ext) begin
        if (rises > 0) chk("b2b_period", 32'(cyc - last_rise), 32'd11);
        rises++;
        last_rise = cyc;
      end
      prev_ext = ext0;
    end
    chk("b2b_strobes", 32'(rises), 32'd4);

    // Full: hold Valid_in while the sequencer is busy
    Valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Data_in = $urandom;
      tick();
    end
    chk("full_level", {29'h0, lvl0}, 32'd4);
    chk("full_ready", {31'h0, rdy0}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      Data_in = $urandom;
      tick();
    end
    Valid_in = 1'b0;
    repeat (70) tick();

    // Reset while HIGH with three words queued
    Valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Data_in = $urandom;
      tick();
    end
    Valid_in = 1'b0;
    tick();
    chk("prerst_level", {29'h0, lvl0}, 32'd3);
    chk("prerst_ext", {31'h0, ext0}, 32'h1);
    #2 Rst_n = 1'b0;
    m_n[0] = 0;
    m_n[1] = 0;
    #1;
    chk("rst_mid_ext", {31'h0, ext0}, 32'h0);
    chk("rst_mid_gpio", gpio0, 32'h0);
    chk("rst_mid_level", {29'h0, lvl0}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy0}, 32'h0);
    repeat (2) tick();
    Rst_n = 1'b1;
    repeat (30) tick();

    // Short-phase instance: simultaneous push and pop keep the level at 1
    Valid_in = 1'b1;
    Data_in  = 32'h12345678;
    tick();
    chk("pp_level_push", {29'h0, lvl1}, 32'd1);
    Data_in  = 32'h87654321;
    tick();
    chk("pp_level_pushpop", {29'h0, lvl1}, 32'd1);
    Valid_in = 1'b0;
    repeat (30) tick();

    // Random traffic on both instances
    for (int i = 0; i < 300; i++) begin
      Valid_in = ($urandom_range(0, 3) != 0);
      Data_in  = $urandom;
      tick();
    end
    Valid_in = 1'b0;
    repeat (80) tick();
    chk("final_idle", {31'h0, busy0}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
